// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 16-bit 5-stage core: load-use stalls,
// taken-branch flushes, memory waits with timeout, halt, and a stall counter.
module pipeline_hazard_ctrl #(
  parameter int REG_W       = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  input  logic             perf_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2,
    S_TIMEOUT  = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic load_use;
  logic mem_stall;
  logic run_decode;
  logic pc_we, ifid_we, flush, bubble, hold;

  assign load_use = idex_mem_read && (idex_rd != '0) &&
                    ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                     (ifid_use_rs2 && (ifid_rs2 == idex_rd)));
  assign mem_stall = mem_req && !mem_ready;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pc_we      = 1'b0;
    ifid_we    = 1'b0;
    flush      = 1'b0;
    bubble     = 1'b0;
    hold       = 1'b0;
    run_decode = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          hold       = 1'b1;
          state_d    = S_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else begin
          run_decode = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (mem_ready) begin
          // The exit cycle behaves as RUN, so a branch or load-use that waited
          // behind the memory access is acted on now.
          run_decode = 1'b1;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          hold    = 1'b1;
          state_d = S_TIMEOUT;
        end else begin
          hold       = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_HALT: begin
        // A pending memory access still freezes the back end; while frozen,
        // no bubble is injected.
        hold   = mem_stall;
        bubble = !mem_stall;
        if (!halt_req) state_d = S_RUN;
      end
      S_TIMEOUT: begin
        hold = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    if (run_decode) begin
      state_d = S_RUN;
      if (branch_taken) begin
        pc_we  = 1'b1;
        flush  = 1'b1;
        bubble = 1'b1;
      end else if (halt_req) begin
        bubble  = 1'b1;
        state_d = S_HALT;
      end else if (load_use) begin
        bubble = 1'b1;
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (perf_clr) begin
      stall_cycles_d = '0;
    end else if (!pc_we && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its peers, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      wait_cnt_q     <= 8'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Mealy outputs are forced low while reset is asserted.
  assign pc_write     = rst_n && pc_we;
  assign ifid_write   = rst_n && ifid_we;
  assign ifid_flush   = rst_n && flush;
  assign idex_bubble  = rst_n && bubble;
  assign pipe_hold    = rst_n && hold;
  assign halted       = rst_n && (state_q == S_HALT);
  assign mem_timeout  = rst_n && (state_q == S_TIMEOUT);
  assign stall_cycles = stall_cycles_q;

  a_hold_excludes_nop: assert property (@(posedge clk) disable iff (!rst_n)
    pipe_hold |-> (!ifid_flush && !idex_bubble));
  a_pc_excludes_hold: assert property (@(posedge clk) disable iff (!rst_n)
    pc_write |-> !pipe_hold);
  a_timeout_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    mem_timeout |=> mem_timeout);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 4;
  localparam int CNT_W = 16;

  // Output vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, halted, mem_timeout}
  localparam logic [6:0] O_RUN   = 7'b1100000;
  localparam logic [6:0] O_STALL = 7'b0001000;
  localparam logic [6:0] O_BR    = 7'b1011000;
  localparam logic [6:0] O_HOLD  = 7'b0000100;
  localparam logic [6:0] O_HLT   = 7'b0001010;
  localparam logic [6:0] O_HLTHD = 7'b0000110;
  localparam logic [6:0] O_TO    = 7'b0000101;
  localparam logic [6:0] O_RST   = 7'b0000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [REG_W-1:0] ifid_rs1, ifid_rs2, idex_rd;
  logic             ifid_use_rs1, ifid_use_rs2, idex_mem_read;
  logic             branch_taken, mem_req, mem_ready, halt_req, perf_clr;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
  logic             pipe_hold, halted, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .halt_req(halt_req), .perf_clr(perf_clr),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .halted(halted),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  wire [6:0] obs = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, halted, mem_timeout};

  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ifid_rs1 = '0; ifid_rs2 = '0; ifid_use_rs1 = 0; ifid_use_rs2 = 0;
    idex_mem_read = 0; idex_rd = '0; branch_taken = 0;
    mem_req = 0; mem_ready = 0; halt_req = 0; perf_clr = 0;
  endtask

  task automatic set_load(input logic [REG_W-1:0] rd,
                          input logic [REG_W-1:0] rs1, input logic use1,
                          input logic [REG_W-1:0] rs2, input logic use2);
    idex_mem_read = 1; idex_rd = rd;
    ifid_rs1 = rs1; ifid_use_rs1 = use1;
    ifid_rs2 = rs2; ifid_use_rs2 = use2;
  endtask

  // Check outputs for the current cycle's inputs, then advance the expected
  // stall count and move to just after the next rising edge.
  task automatic sample(input string tag, input logic [6:0] exp_o);
    @(negedge clk);
    check({tag, "/out"}, 32'(obs), 32'(exp_o));
    check({tag, "/stall"}, 32'(stall_cycles), 32'(exp_stall));
    if (perf_clr) exp_stall = '0;
    else if (!exp_o[6] && exp_stall != '1) exp_stall = exp_stall + 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 0;
    #1;
    check({tag, "/out"}, 32'(obs), 32'(O_RST));
    check({tag, "/stall"}, 32'(stall_cycles), 32'd0);
    exp_stall = '0;
    @(posedge clk); #1;
    idle();
    rst_n = 1;
  endtask

  initial begin
    idle();
    exp_stall = '0;
    rst_n = 0;
    mem_req = 1;          // would raise pipe_hold if outputs were not gated
    #2;
    check("rst/out", 32'(obs), 32'(O_RST));
    check("rst/stall", 32'(stall_cycles), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    idle();
    rst_n = 1;

    // Load-use stalls
    sample("run_idle", O_RUN);
    set_load(4'd3, 4'd3, 1, 4'd5, 1);
    sample("lu_rs1", O_STALL);
    idle();
    sample("lu_resume", O_RUN);
    set_load(4'd0, 4'd0, 1, 4'd0, 1);
    sample("lu_rd0", O_RUN);
    set_load(4'd5, 4'd3, 1, 4'd5, 1);
    sample("lu_rs2", O_STALL);
    set_load(4'd3, 4'd3, 0, 4'd7, 1);
    sample("lu_nouse", O_RUN);
    set_load(4'd3, 4'd3, 1, 4'd5, 1);
    idex_mem_read = 0;
    sample("lu_noload", O_RUN);

    // Branch overrides load-use
    set_load(4'd3, 4'd3, 1, 4'd5, 1);
    branch_taken = 1;
    sample("br_lu", O_BR);
    idle();
    sample("br_after", O_RUN);

    // Memory wait with a branch held throughout
    mem_req = 1; branch_taken = 1;
    sample("mw_0", O_HOLD);
    sample("mw_1", O_HOLD);
    sample("mw_2", O_HOLD);
    mem_ready = 1;
    sample("mw_exit_br", O_BR);
    idle();
    sample("mw_after", O_RUN);

    // Memory wait exiting into a load-use stall
    mem_req = 1;
    sample("mw2_0", O_HOLD);
    mem_ready = 1;
    set_load(4'd2, 4'd9, 0, 4'd2, 1);
    sample("mw2_exit_lu", O_STALL);
    idle();
    sample("mw2_after", O_RUN);

    // Counter clear
    perf_clr = 1;
    sample("clr", O_RUN);
    perf_clr = 0;
    sample("clr_after", O_RUN);

    // Halt for five cycles, with a memory stall and an ignored branch inside
    halt_req = 1;
    sample("hlt_entry", O_STALL);
    sample("hlt_1", O_HLT);
    mem_req = 1;
    sample("hlt_memhold", O_HLTHD);
    mem_req = 0; branch_taken = 1;
    sample("hlt_br_ignored", O_HLT);
    branch_taken = 0;
    sample("hlt_4", O_HLT);
    halt_req = 0;
    sample("hlt_release", O_HLT);
    sample("hlt_run", O_RUN);

    // Memory timeout after four wait cycles, sticky until reset
    mem_req = 1;
    sample("to_run", O_HOLD);
    sample("to_w1", O_HOLD);
    sample("to_w2", O_HOLD);
    sample("to_w3", O_HOLD);
    sample("to_w4", O_HOLD);
    sample("to_hit", O_TO);
    mem_ready = 1; halt_req = 1; branch_taken = 1;
    sample("to_sticky", O_TO);
    reset_pulse("to_rst");
    sample("to_after_rst", O_RUN);

    // Reset in the middle of a memory wait
    mem_req = 1;
    sample("mwr_0", O_HOLD);
    sample("mwr_1", O_HOLD);
    reset_pulse("mwr_rst");
    sample("mwr_after", O_RUN);

    // Saturation: 65540 stall cycles from zero
    halt_req = 1;
    repeat (65540) @(posedge clk);
    #1;
    exp_stall = '1;
    sample("sat_0", O_HLT);
    sample("sat_1", O_HLT);
    perf_clr = 1;
    sample("sat_clr", O_HLT);
    perf_clr = 0; halt_req = 0;
    sample("sat_release", O_HLT);
    sample("sat_run", O_RUN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
